// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ valid/ready requesters and returns a tagged result.
// Define ALU_ARB_FIXED_PRIO_EN to use fixed priority (lowest index wins) instead of round-robin.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ARCH    = 32,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    input  logic [NUM_REQ*4-1:0]    req_ctrl_in,
    input  logic [NUM_REQ*ARCH-1:0] req_a_in,
    input  logic [NUM_REQ*ARCH-1:0] req_b_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    output logic [3:0]              alu_ctrl_out,
    output logic [ARCH-1:0]         alu_a_out,
    output logic [ARCH-1:0]         alu_b_out,
    input  logic [ARCH-1:0]         alu_result_in,
    input  logic                    alu_zero_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic [ID_W-1:0]         resp_id_out,
    output logic [ARCH-1:0]         resp_result_out,
    output logic                    resp_zero_out,
    output logic [1:0]              state_dbg_out
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // the sender holds valid and payload stable until then, and ready never waits on a later cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            any_req;
    logic            grant;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] resp_id_q;
    logic [3:0]      ctrl_q;
    logic [ARCH-1:0] a_q, b_q, res_q;
    logic            zero_q;

    logic [3:0]      ctrl_arr [NUM_REQ];
    logic [ARCH-1:0] a_arr    [NUM_REQ];
    logic [ARCH-1:0] b_arr    [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign ctrl_arr[g] = req_ctrl_in[4*g +: 4];
        assign a_arr[g]    = req_a_in[ARCH*g +: ARCH];
        assign b_arr[g]    = req_b_in[ARCH*g +: ARCH];
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_in[i]) winner = ID_W'(i);
        end
    end
`else
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] cand;
    int              cand_i;
    logic            found;

    // Search starts just after the last winner and wraps, so every holder is served within NUM_REQ grants.
    always_comb begin
        winner = '0;
        cand   = '0;
        cand_i = 0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
            cand = ID_W'(cand_i);
            if (!found && req_valid_in[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    assign any_req = |req_valid_in;
    assign grant   = !rst_in && any_req &&
                     ((state_q == IDLE) || ((state_q == RESP) && resp_ready_in));

    always_comb begin
        req_ready_out = '0;
        if (grant) req_ready_out[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready_in) state_d = grant ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            resp_id_q <= '0;
            res_q     <= '0;
            zero_q    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q     <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            if (grant) begin
                ctrl_q <= ctrl_arr[winner];
                a_q    <= a_arr[winner];
                b_q    <= b_arr[winner];
                id_q   <= winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
                ptr_q  <= winner;
`endif
            end
            // The ALU output is only meaningful while the operand regs drive it in EXEC.
            if (state_q == EXEC) begin
                res_q     <= alu_result_in;
                zero_q    <= alu_zero_in;
                resp_id_q <= id_q;
            end
        end
    end

    assign alu_ctrl_out    = ctrl_q;
    assign alu_a_out       = a_q;
    assign alu_b_out       = b_q;
    assign resp_valid_out  = (state_q == RESP);
    assign resp_id_out     = resp_id_q;
    assign resp_result_out = res_q;
    assign resp_zero_out   = zero_q;
    assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: a transaction-level model predicts grants and
// responses; a separate monitor checks every response cycle against the expected queue.
module tb_alu_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ARCH    = 32;
    localparam int ID_W    = 1;

    // Stand-in ctrl encodings for the shared ALU; codes 10..15 are unknown and yield 0.
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [NUM_REQ-1:0]      req_valid_in;
    logic [NUM_REQ*4-1:0]    req_ctrl_in;
    logic [NUM_REQ*ARCH-1:0] req_a_in;
    logic [NUM_REQ*ARCH-1:0] req_b_in;
    logic [NUM_REQ-1:0]      req_ready_out;
    logic [3:0]              alu_ctrl_out;
    logic [ARCH-1:0]         alu_a_out;
    logic [ARCH-1:0]         alu_b_out;
    logic [ARCH-1:0]         alu_result;
    logic                    alu_zero;
    logic                    resp_valid_out;
    logic                    resp_ready_in;
    logic [ID_W-1:0]         resp_id_out;
    logic [ARCH-1:0]         resp_result_out;
    logic                    resp_zero_out;
    logic [1:0]              state_dbg;

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ARCH(ARCH), .ID_W(ID_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ctrl_in(req_ctrl_in),
        .req_a_in(req_a_in), .req_b_in(req_b_in), .req_ready_out(req_ready_out),
        .alu_ctrl_out(alu_ctrl_out), .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .alu_result_in(alu_result), .alu_zero_in(alu_zero),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_id_out(resp_id_out), .resp_result_out(resp_result_out),
        .resp_zero_out(resp_zero_out), .state_dbg_out(state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- shared ALU model ----------------
    function automatic logic [ARCH-1:0] alu_f(input logic [3:0] c, input logic [ARCH-1:0] a,
                                              input logic [ARCH-1:0] b);
        case (c)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $signed(a) >>> b[4:0];
            OP_SLT:  return ($signed(a) < $signed(b)) ? {{(ARCH-1){1'b0}}, 1'b1} : '0;
            OP_SLTU: return (a < b) ? {{(ARCH-1){1'b0}}, 1'b1} : '0;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_ctrl_out, alu_a_out, alu_b_out);
    assign alu_zero   = (alu_result == '0);

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]     cyc;
        logic [ID_W-1:0] id;
        logic            zero;
        logic [ARCH-1:0] res;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_winner(input logic [NUM_REQ-1:0] v, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
        return 0;
    endfunction

    // Transaction-level model: one op in flight, visible two cycles after its grant,
    // and the unit is free again on the cycle its response is consumed.
    int              m_ptr = NUM_REQ - 1;
    bit              m_busy = 1'b0;
    int              m_resp_at = 0;
    logic [3:0]      m_ctrl = '0;
    logic [ARCH-1:0] m_a = '0;
    logic [ARCH-1:0] m_b = '0;

    always @(negedge clk_in) begin : grant_model
        logic [NUM_REQ-1:0] exp_g;
        int                 w;
        exp_t               e;
        if (rst_in) begin
            check("ready_in_reset", req_ready_out, 0);
            m_ptr  = NUM_REQ - 1;
            m_busy = 1'b0;
            m_ctrl = '0;
            m_a    = '0;
            m_b    = '0;
        end else begin
            check("alu_ctrl", alu_ctrl_out, m_ctrl);
            check("alu_a", alu_a_out, m_a);
            check("alu_b", alu_b_out, m_b);
            if (m_busy && cyc >= m_resp_at && resp_ready_in) m_busy = 1'b0;
            exp_g = '0;
            if (!m_busy && req_valid_in != '0) begin
                w        = pick_winner(req_valid_in, m_ptr);
                exp_g[w] = 1'b1;
                m_ctrl   = req_ctrl_in[4*w +: 4];
                m_a      = req_a_in[ARCH*w +: ARCH];
                m_b      = req_b_in[ARCH*w +: ARCH];
                e.res    = alu_f(m_ctrl, m_a, m_b);
                e.zero   = (e.res == '0);
                e.id     = ID_W'(w);
                e.cyc    = 32'(cyc + 2);
                exp_q.push_back(e);
                m_busy    = 1'b1;
                m_resp_at = cyc + 2;
                m_ptr     = w;
            end
            check("grant", req_ready_out, exp_g);
        end
    end

    bit r_prev_rst = 1'b0;
    always @(negedge clk_in) begin : resp_monitor
        exp_t e;
        if (rst_in) begin
            exp_q.delete();
        end else begin
            if (r_prev_rst) begin
                check("reset_state", state_dbg, 0);
                check("reset_resp_id", resp_id_out, 0);
                check("reset_resp_result", resp_result_out, 0);
                check("reset_resp_zero", resp_zero_out, 0);
            end
            if (exp_q.size() == 0) begin
                check("resp_valid_idle", resp_valid_out, 0);
            end else begin
                e = exp_q[0];
                if (cyc < int'(e.cyc)) begin
                    check("resp_valid_early", resp_valid_out, 0);
                end else begin
                    check("resp_valid", resp_valid_out, 1);
                    check("resp_id", resp_id_out, e.id);
                    check("resp_result", resp_result_out, e.res);
                    check("resp_zero", resp_zero_out, e.zero);
                    if (resp_valid_out && resp_ready_in) void'(exp_q.pop_front());
                end
            end
        end
        r_prev_rst = rst_in;
    end

    // ---------------- driver ----------------
    logic [NUM_REQ-1:0] granted;

    task automatic tick();
        @(negedge clk_in);
        granted = req_ready_out;
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] c,
                           input logic [ARCH-1:0] a, input logic [ARCH-1:0] b);
        req_valid_in[i]            = v;
        req_ctrl_in[4*i +: 4]      = c;
        req_a_in[ARCH*i +: ARCH]   = a;
        req_b_in[ARCH*i +: ARCH]   = b;
    endtask

    task automatic wait_grant(input int i);
        for (int t = 0; t < 20; t++) begin
            tick();
            if (granted[i]) break;
        end
    endtask

    function automatic logic [ARCH-1:0] rand_opnd();
        if ($urandom_range(0, 3) == 0) return ARCH'($urandom_range(0, 7));
        return ARCH'($urandom);
    endfunction

    initial begin
        rst_in        = 1'b1;
        req_valid_in  = '0;
        req_ctrl_in   = '0;
        req_a_in      = '0;
        req_b_in      = '0;
        resp_ready_in = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;

        // single request: ADD 5+7
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        wait_grant(0);
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (4) tick();

        // contention held from reset: SUB 3-3 vs XOR F0^0F, alternating grants
        rst_in = 1'b1;
        set_req(0, 1'b1, OP_SUB, 32'd3, 32'd3);
        set_req(1, 1'b1, OP_XOR, 32'h0000_00F0, 32'h0000_000F);
        repeat (2) tick();
        rst_in = 1'b0;
        repeat (14) tick();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (4) tick();

        // backpressure with req1 pending, then handshake and grant together
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        wait_grant(0);
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b1, OP_OR, 32'h10, 32'h01);
        resp_ready_in = 1'b0;
        repeat (6) tick();
        resp_ready_in = 1'b1;
        wait_grant(1);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (4) tick();

        // back-to-back SLL 1<<4
        set_req(0, 1'b1, OP_SLL, 32'd1, 32'd4);
        repeat (16) tick();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (4) tick();

        // reset while EXEC; afterwards requester 0 wins first
        set_req(1, 1'b1, OP_ADD, 32'd2, 32'd2);
        repeat (3) tick();
        set_req(0, 1'b1, OP_ADD, 32'd9, 32'd9);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (2) tick();
        wait_grant(0);
        rst_in = 1'b1;
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        tick();
        rst_in = 1'b0;
        set_req(0, 1'b1, OP_AND, 32'hFF, 32'h0F);
        set_req(1, 1'b1, OP_SUB, 32'd10, 32'd4);
        repeat (8) tick();
        set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
        set_req(1, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (4) tick();

        // randomized traffic with backpressure and occasional resets
        for (int c = 0; c < 1500; c++) begin
            tick();
            rst_in = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (granted[i] || !req_valid_in[i]) begin
                    set_req(i, ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)),
                            rand_opnd(), rand_opnd());
                end
            end
            resp_ready_in = ($urandom_range(0, 99) < 70);
        end

        rst_in        = 1'b0;
        resp_ready_in = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, OP_ADD, '0, '0);
        repeat (8) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
